// File: rtl/i2c_target_core.sv
`timescale 1ns/1ps
// i2c_target_core
// I2C target byte engine. It detects START/STOP, matches a 7-bit address, ACKs or
// NACKs, shifts bytes in and out, and stretches SCL while the parent is not ready.
// Ports:
//   clk, rst (async, active-low)
//   scl_i/sda_i  bus samples; scl_o/sda_o constant 0; scl_oe/sda_oe pull the line low
//   start/rw     address matched (pulse) and R/W bit (held)
//   rx_data/rx_valid/rx_ready/rx_ack   write-byte handshake
//   tx_req/tx_data/tx_valid            read-byte handshake
//   stop (pulse), busy (level)
module i2c_target_core #(
    parameter logic [6:0]  I2C_ADDR    = 7'h50,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter bit          STRETCH_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_oe,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oe,
    output logic       start,
    output logic       rw,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       rx_ack,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       stop,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, IGNORE, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d, hold_q, hold_d;
    logic [7:0]  shift_q, shift_d, rx_data_q, rx_data_d;
    logic        in_ack_q, in_ack_d, ack_done_q, ack_done_d, ack_val_q, ack_val_d;
    logic        sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic        start_q, start_d, rw_q, rw_d, rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d, stop_q, stop_d, busy_q, busy_d;
    logic        sda_want, stretch_wr, stretch_rd, settle;

    // [0],[1] are the synchroniser, [2] is the previous synced value for edge detect.
    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_now    = scl_sync_q[1];
    assign scl_prev   = scl_sync_q[2];
    assign sda_now    = sda_sync_q[1];
    assign sda_prev   = sda_sync_q[2];
    assign scl_rise   = scl_now & ~scl_prev;
    assign scl_fall   = ~scl_now & scl_prev;
    assign start_cond = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_cond  = scl_now & scl_prev & ~sda_prev & sda_now;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_i};
        sda_sync_d = {sda_sync_q[1:0], sda_i};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        in_ack_d   = in_ack_q;
        ack_done_d = ack_done_q;
        ack_val_d  = ack_val_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        start_d    = 1'b0;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        stop_d     = 1'b0;
        hold_d     = scl_fall ? HOLD_LOAD : ((hold_q != 4'd0) ? hold_q - 4'd1 : hold_q);

        case (state_q)
            ADDR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_now};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (shift_q[6:0] == I2C_ADDR) begin
                            state_d  = ADDR_ACK;
                            start_d  = 1'b1;
                            rw_d     = sda_now;
                            in_ack_d = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
            end
            // in_ack marks that the fall opening the ACK clock has been seen;
            // the next fall closes it.
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (!in_ack_q) begin
                        in_ack_d = 1'b1;
                    end else if (rw_q) begin
                        state_d  = RD_WAIT;
                        tx_req_d = 1'b1;
                    end else begin
                        state_d   = WR_DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
            end
            WR_DATA: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_now};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rx_data_d  = {shift_q[6:0], sda_now};
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                        in_ack_d   = 1'b0;
                        ack_done_d = 1'b0;
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    if (!in_ack_q) begin
                        in_ack_d = 1'b1;
                    end else if (ack_done_q && ack_val_q) begin
                        state_d   = WR_DATA;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d = IGNORE;
                    end
                end else if (in_ack_q && !ack_done_q) begin
                    if (rx_ready) begin
                        ack_done_d = 1'b1;
                        ack_val_d  = rx_ack;
                    end else if (!STRETCH_EN) begin
                        ack_done_d = 1'b1;
                        ack_val_d  = 1'b0;
                    end
                end
            end
            RD_WAIT: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    bit_cnt_d = 4'd0;
                    state_d   = RD_DATA;
                end else if (!STRETCH_EN) begin
                    shift_d   = 8'hFF;
                    bit_cnt_d = 4'd0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d  = RD_ACK;
                        in_ack_d = 1'b0;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            // The master's ACK is sampled on the rise, but the move to RD_WAIT waits
            // for the fall so that stretching never starts while SCL is high.
            RD_ACK: begin
                if (scl_rise) begin
                    in_ack_d  = 1'b1;
                    ack_val_d = ~sda_now;
                end else if (scl_fall && in_ack_q) begin
                    if (ack_val_q) begin
                        state_d  = RD_WAIT;
                        tx_req_d = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            IDLE, IGNORE: ;
            default: state_d = IDLE;
        endcase

        if (stop_cond) begin
            stop_d  = (state_q != IDLE);
            state_d = IDLE;
        end else if (start_cond) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
        end
        busy_d = (state_d != IDLE);

        case (state_q)
            ADDR_ACK: sda_want = in_ack_q;
            WR_ACK:   sda_want = in_ack_q & ack_done_q & ack_val_q;
            RD_DATA:  sda_want = ~shift_q[7];
            default:  sda_want = 1'b0;
        endcase

        // SDA only follows sda_want while SCL is low and the hold time since the
        // last fall has elapsed.
        if (start_cond || stop_cond) begin
            sda_oe_d = 1'b0;
        end else if (!scl_now && !scl_fall && (hold_q == 4'd0)) begin
            sda_oe_d = sda_want;
        end else begin
            sda_oe_d = sda_oe_q;
        end

        // A stretch already in progress is kept one extra cycle after the
        // handshake completes, and then until SDA has settled, so the master
        // never sees SDA move after SCL is let go.
        stretch_wr = (state_q == WR_ACK) && in_ack_q && !ack_done_q && (!rx_ready || scl_oe_q);
        stretch_rd = (state_q == RD_WAIT) && (!tx_valid || scl_oe_q);
        settle     = scl_oe_q && (sda_oe_q != sda_want);
        scl_oe_d   = STRETCH_EN && (stretch_wr || stretch_rd || settle)
                     && (!scl_now || scl_oe_q) && !(start_cond || stop_cond);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            bit_cnt_q  <= 4'd0;
            hold_q     <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            in_ack_q   <= 1'b0;
            ack_done_q <= 1'b0;
            ack_val_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            start_q    <= 1'b0;
            rw_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            in_ack_q   <= in_ack_d;
            ack_done_q <= ack_done_d;
            ack_val_q  <= ack_val_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            start_q    <= start_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign scl_o    = 1'b0;
    assign sda_o    = 1'b0;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign start    = start_q;
    assign rw       = rw_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign stop     = stop_q;
    assign busy     = busy_q;
endmodule
